// File: rtl/cam_config_seq.sv
// Camera register configuration sequencer: replays a ROM table of SCCB writes
// for each camera in turn, with table-embedded delays and per-entry NACK retry.
module cam_config_seq #(
  parameter int unsigned CLK_FREQ    = 25000000,
  parameter int unsigned I2C_ADDR_16 = 0,
  parameter int unsigned NUM_CAMS    = 2,
  parameter int unsigned ROM_AW      = 10,
  parameter int unsigned MAX_RETRY   = 3,
  localparam int unsigned CW = (NUM_CAMS > 1) ? $clog2(NUM_CAMS) : 1,
  localparam int unsigned DW = 16 + 8 * I2C_ADDR_16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [DW-1:0]     rom_data,
  output logic [CW-1:0]     cam_sel,
  input  logic              sccb_ready,
  input  logic              sccb_nack,
  output logic [DW-9:0]     sccb_addr,
  output logic [7:0]        sccb_data,
  output logic              sccb_start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CW-1:0]     err_cam
);

  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [CW-1:0] LAST_CAM  = CW'(NUM_CAMS - 1);
  localparam logic [31:0]   T_50MS    = 32'(CLK_FREQ / 20);
  localparam logic [31:0]   T_10MS    = 32'(CLK_FREQ / 100);

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, SEND, WAIT_LO, WAIT_HI, TIMER, NEXT_CAM, FIN
  } state_t;

  state_t            state, state_d;
  logic [ROM_AW-1:0] rom_addr_d;
  logic [CW-1:0]     cam_sel_d, err_cam_d;
  logic [RW-1:0]     retry, retry_d;
  logic [31:0]       timer, timer_d;
  logic [DW-9:0]     sccb_addr_d;
  logic [7:0]        sccb_data_d;
  logic              sccb_start_d, busy_d, done_d, error_d;
  logic [1:0]        lo_cnt, lo_cnt_d;
  logic              ret_cam, ret_cam_d;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rom_addr   <= '0;
      cam_sel    <= '0;
      retry      <= '0;
      timer      <= '0;
      sccb_addr  <= '0;
      sccb_data  <= '0;
      sccb_start <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      err_cam    <= '0;
      lo_cnt     <= '0;
      ret_cam    <= 1'b0;
    end else begin
      state      <= state_d;
      rom_addr   <= rom_addr_d;
      cam_sel    <= cam_sel_d;
      retry      <= retry_d;
      timer      <= timer_d;
      sccb_addr  <= sccb_addr_d;
      sccb_data  <= sccb_data_d;
      sccb_start <= sccb_start_d;
      busy       <= busy_d;
      done       <= done_d;
      error      <= error_d;
      err_cam    <= err_cam_d;
      lo_cnt     <= lo_cnt_d;
      ret_cam    <= ret_cam_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d      = state;
    rom_addr_d   = rom_addr;
    cam_sel_d    = cam_sel;
    retry_d      = retry;
    timer_d      = timer;
    sccb_addr_d  = sccb_addr;
    sccb_data_d  = sccb_data;
    sccb_start_d = 1'b0;
    busy_d       = busy;
    done_d       = done;
    error_d      = error;
    err_cam_d    = err_cam;
    lo_cnt_d     = lo_cnt;
    ret_cam_d    = ret_cam;

    case (state)
      IDLE: begin
        if (start) begin
          done_d     = 1'b0;
          error_d    = 1'b0;
          err_cam_d  = '0;
          rom_addr_d = '0;
          cam_sel_d  = '0;
          retry_d    = '0;
          busy_d     = 1'b1;
          state_d    = FETCH;
        end
      end
      FETCH: state_d = DECODE;
      DECODE: begin
        if (rom_data[15:0] == 16'hFFFF) begin
          timer_d   = T_50MS;
          ret_cam_d = 1'b1;
          state_d   = TIMER;
        end else if (rom_data[15:0] == 16'hFFF0) begin
          timer_d    = T_10MS;
          ret_cam_d  = 1'b0;
          rom_addr_d = rom_addr + ROM_AW'(1);
          state_d    = TIMER;
        end else begin
          sccb_addr_d = rom_data[DW-1:8];
          sccb_data_d = rom_data[7:0];
          state_d     = SEND;
        end
      end
      // The start pulse is issued and retired while still in SEND
      SEND: begin
        if (sccb_start) begin
          lo_cnt_d = '0;
          state_d  = WAIT_LO;
        end else if (sccb_ready) begin
          sccb_start_d = 1'b1;
        end
      end
      WAIT_LO: begin
        if (!sccb_ready || lo_cnt == 2'd3) state_d = WAIT_HI;
        else lo_cnt_d = lo_cnt + 2'd1;
      end
      WAIT_HI: begin
        if (sccb_ready) begin
          if (!sccb_nack) begin
            rom_addr_d = rom_addr + ROM_AW'(1);
            retry_d    = '0;
            state_d    = FETCH;
          end else if (retry < RETRY_MAX) begin
            retry_d = retry + RW'(1);
            state_d = SEND;
          end else begin
            error_d   = 1'b1;
            err_cam_d = cam_sel;
            state_d   = FIN;
          end
        end
      end
      TIMER: begin
        if (timer == 32'd0) state_d = ret_cam ? NEXT_CAM : FETCH;
        else timer_d = timer - 32'd1;
      end
      NEXT_CAM: begin
        if (cam_sel != LAST_CAM) begin
          cam_sel_d  = cam_sel + CW'(1);
          rom_addr_d = '0;
          state_d    = FETCH;
        end else begin
          state_d = FIN;
        end
      end
      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cam_config_seq.sv
// Self-checking bench for cam_config_seq: table of ROM/NACK scenarios scored
// against an expected-transfer queue, plus reset and 16-bit address sequences.
module tb_cam_config_seq;

  localparam int unsigned CLK_FREQ  = 1000;
  localparam int unsigned MAX_RETRY = 3;
  localparam int unsigned N50       = CLK_FREQ / 20;
  localparam int unsigned N10       = CLK_FREQ / 100;

  logic        clk, rst_n, start;
  logic [9:0]  rom_addr;
  logic [15:0] rom_data;
  logic        cam_sel;
  logic        sccb_ready, sccb_nack;
  logic [7:0]  sccb_addr, sccb_data;
  logic        sccb_start, busy, done, error, err_cam;

  logic        start2;
  logic [9:0]  rom_addr2;
  logic [23:0] rom_data2;
  logic        cam_sel2;
  logic        ready2, nack2;
  logic [15:0] addr2;
  logic [7:0]  data2;
  logic        sccb_start2, busy2, done2, error2, err_cam2;

  cam_config_seq #(.CLK_FREQ(CLK_FREQ), .I2C_ADDR_16(0), .NUM_CAMS(2),
                   .ROM_AW(10), .MAX_RETRY(MAX_RETRY)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rom_addr(rom_addr),
    .rom_data(rom_data), .cam_sel(cam_sel), .sccb_ready(sccb_ready),
    .sccb_nack(sccb_nack), .sccb_addr(sccb_addr), .sccb_data(sccb_data),
    .sccb_start(sccb_start), .busy(busy), .done(done), .error(error),
    .err_cam(err_cam));

  cam_config_seq #(.CLK_FREQ(CLK_FREQ), .I2C_ADDR_16(1), .NUM_CAMS(1),
                   .ROM_AW(10), .MAX_RETRY(MAX_RETRY)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .rom_addr(rom_addr2),
    .rom_data(rom_data2), .cam_sel(cam_sel2), .sccb_ready(ready2),
    .sccb_nack(nack2), .sccb_addr(addr2), .sccb_data(data2),
    .sccb_start(sccb_start2), .busy(busy2), .done(done2), .error(error2),
    .err_cam(err_cam2));

  typedef struct {
    logic [0:3][15:0] rom;
    int               nack_cam;
    logic [15:0]      nack_word;
    int               nack_times;
    bit               fast;
    int               exp_xfers;
    bit               exp_err;
    bit               exp_cam;
  } vec_t;

  typedef struct packed {
    logic       cam;
    logic [7:0] addr;
    logic [7:0] data;
  } xfer_t;

  vec_t             vecs [7];
  xfer_t            exp_q [$];
  logic [0:3][15:0] cur_rom;
  int               nk_cam, nk_left;
  logic [15:0]      nk_word;
  bit               fast_mode;
  int               total, bad, cyc, nstarts;
  int               t_a2, t_c1, t_s2;
  logic [9:0]       prev_addr;
  logic             prev_cam;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous table ROMs
  always @(posedge clk) rom_data <= cur_rom[rom_addr[1:0]];
  always @(posedge clk) rom_data2 <= (rom_addr2 == 10'd0) ? 24'h300A56 : 24'h00FFFF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // SCCB master model: drops ready for a few cycles (or not, in fast mode)
  task automatic slave_loop();
    logic nk;
    forever begin
      @(negedge clk);
      if (rst_n && sccb_start) begin
        nk = (int'(cam_sel) == nk_cam) && ({sccb_addr, sccb_data} == nk_word) && (nk_left > 0);
        if (nk) nk_left--;
        @(posedge clk);
        #1;
        if (fast_mode) sccb_nack = nk;
        else begin
          sccb_ready = 1'b0;
          repeat (3) @(posedge clk);
          #1;
          sccb_nack  = nk;
          sccb_ready = 1'b1;
        end
      end
    end
  endtask

  // Scoreboard consumer and timing markers
  task automatic mon_loop();
    xfer_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        if (rom_addr == 10'd2 && prev_addr != 10'd2 && t_a2 < 0) t_a2 = cyc;
        if (cam_sel && !prev_cam && t_c1 < 0) t_c1 = cyc;
        if (sccb_start) begin
          nstarts++;
          if (t_a2 >= 0 && t_s2 < 0) t_s2 = cyc;
          if (exp_q.size() == 0) check("spurious_start", 32'(exp_q.size()), 32'd1);
          else begin
            e = exp_q.pop_front();
            check("xfer_cam", 32'(cam_sel), 32'(e.cam));
            check("xfer_addr", 32'(sccb_addr), 32'(e.addr));
            check("xfer_data", 32'(sccb_data), 32'(e.data));
          end
        end
      end
      prev_addr = rom_addr;
      prev_cam  = cam_sel;
    end
  endtask

  function automatic logic cond(input int w);
    case (w)
      0: return sccb_start;
      1: return !sccb_ready;
      2: return sccb_ready;
      3: return sccb_start2;
      default: return done2;
    endcase
  endfunction

  task automatic wait_cond(input string name, input int w);
    int n = 0;
    while (!cond(w) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(cond(w)), 32'd1);
  endtask

  // Load a scenario and build its expected transfer list
  task automatic setup(input int i);
    vec_t        v;
    logic [15:0] w;
    int          tries;
    bit          aborted;
    v         = vecs[i];
    cur_rom   = v.rom;
    nk_cam    = v.nack_cam;
    nk_word   = v.nack_word;
    nk_left   = v.nack_times;
    fast_mode = v.fast;
    exp_q.delete();
    aborted = 1'b0;
    for (int c = 0; c < 2 && !aborted; c++) begin
      for (int k = 0; k < 4; k++) begin
        w = v.rom[k];
        if (w == 16'hFFFF) break;
        if (w == 16'hFFF0) continue;
        tries = (c == v.nack_cam && w == v.nack_word) ? v.nack_times : 0;
        if (tries > int'(MAX_RETRY)) begin
          tries   = int'(MAX_RETRY);
          aborted = 1'b1;
        end
        for (int r = 0; r <= tries; r++) exp_q.push_back('{cam: 1'(c), addr: w[15:8], data: w[7:0]});
        if (aborted) break;
      end
    end
    t_a2 = -1; t_c1 = -1; t_s2 = -1; nstarts = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic run_vec(input int i);
    int n = 0;
    setup(i);
    pulse_start();
    check("accept_busy", 32'(busy), 32'd1);
    check("accept_done_clr", 32'(done), 32'd0);
    check("accept_err_clr", 32'(error), 32'd0);
    check("accept_addr", 32'(rom_addr), 32'd0);
    check("accept_cam", 32'(cam_sel), 32'd0);
    repeat (20) @(negedge clk);
    pulse_start();
    while (!(done && !busy) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check("finish_done", 32'(done), 32'd1);
    check("finish_busy", 32'(busy), 32'd0);
    check("finish_error", 32'(error), 32'(vecs[i].exp_err));
    check("finish_err_cam", 32'(err_cam), 32'(vecs[i].exp_cam));
    check("start_count", 32'(nstarts), 32'(vecs[i].exp_xfers));
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    repeat (5) @(negedge clk);
    check("done_sticky", 32'(done), 32'd1);
    check("error_sticky", 32'(error), 32'(vecs[i].exp_err));
    // FETCH + DECODE + (N+1) TIMER + NEXT_CAM / FETCH + DECODE + SEND
    if (i == 0) check("cam_gap", 32'(t_c1 - t_a2), 32'(N50 + 4));
    if (i == 1) check("delay_gap", 32'(t_s2 - t_a2), 32'(N10 + 4));
  endtask

  initial begin
    vecs[0] = '{rom: {16'h1280, 16'h12A5, 16'hFFFF, 16'hFFFF}, nack_cam: 0, nack_word: 16'h0,    nack_times: 0,  fast: 1'b0, exp_xfers: 4, exp_err: 1'b0, exp_cam: 1'b0};
    vecs[1] = '{rom: {16'h1280, 16'hFFF0, 16'h12A5, 16'hFFFF}, nack_cam: 0, nack_word: 16'h0,    nack_times: 0,  fast: 1'b0, exp_xfers: 4, exp_err: 1'b0, exp_cam: 1'b0};
    vecs[2] = '{rom: {16'h1280, 16'h12A5, 16'hFFFF, 16'hFFFF}, nack_cam: 0, nack_word: 16'h12A5, nack_times: 2,  fast: 1'b0, exp_xfers: 6, exp_err: 1'b0, exp_cam: 1'b0};
    vecs[3] = '{rom: {16'h1280, 16'h12A5, 16'hFFFF, 16'hFFFF}, nack_cam: 1, nack_word: 16'h1280, nack_times: 99, fast: 1'b0, exp_xfers: 6, exp_err: 1'b1, exp_cam: 1'b1};
    vecs[4] = '{rom: {16'h1280, 16'h12A5, 16'hFFFF, 16'hFFFF}, nack_cam: 0, nack_word: 16'h1280, nack_times: 3,  fast: 1'b0, exp_xfers: 7, exp_err: 1'b0, exp_cam: 1'b0};
    vecs[5] = '{rom: {16'h1280, 16'h12A5, 16'hFFFF, 16'hFFFF}, nack_cam: 0, nack_word: 16'h1280, nack_times: 99, fast: 1'b0, exp_xfers: 4, exp_err: 1'b1, exp_cam: 1'b0};
    vecs[6] = '{rom: {16'h3311, 16'h3422, 16'hFFFF, 16'hFFFF}, nack_cam: 0, nack_word: 16'h0,    nack_times: 0,  fast: 1'b1, exp_xfers: 4, exp_err: 1'b0, exp_cam: 1'b0};
    total = 0; bad = 0; cyc = 0; nstarts = 0;
    prev_addr = '0; prev_cam = 1'b0;
    rst_n = 1'b0; start = 1'b0; start2 = 1'b0;
    ready2 = 1'b1; nack2 = 1'b0;
    sccb_ready = 1'b1; sccb_nack = 1'b0;
    setup(0);
    fork
      slave_loop();
      mon_loop();
    join_none

    repeat (3) @(negedge clk);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sccb_start", 32'(sccb_start), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(i);

    // Reset while the start pulse is high
    setup(0);
    pulse_start();
    wait_cond("see_start", 0);
    #1 rst_n = 1'b0;
    #1;
    check("rst_drop_start", 32'(sccb_start), 32'd0);
    check("rst_drop_busy", 32'(busy), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    wait_cond("slave_idle_a", 2);

    // Reset while waiting for the transfer to finish
    setup(0);
    pulse_start();
    wait_cond("see_start_b", 0);
    @(negedge clk);
    wait_cond("in_wait_hi", 1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_hi_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_hi_cam_sel", 32'(cam_sel), 32'd0);
    check("rst_hi_sccb_addr", 32'(sccb_addr), 32'd0);
    check("rst_hi_sccb_data", 32'(sccb_data), 32'd0);
    check("rst_hi_sccb_start", 32'(sccb_start), 32'd0);
    check("rst_hi_busy", 32'(busy), 32'd0);
    check("rst_hi_done", 32'(done), 32'd0);
    check("rst_hi_error", 32'(error), 32'd0);
    check("rst_hi_err_cam", 32'(err_cam), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    wait_cond("slave_idle_b", 2);
    repeat (8) @(negedge clk);
    check("idle_after_rst", 32'(busy), 32'd0);
    run_vec(0);

    // 16-bit register address variant, single camera
    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
    wait_cond("see_start2", 3);
    check("a16_addr", 32'(addr2), 32'h300A);
    check("a16_data", 32'(data2), 32'h56);
    check("a16_cam", 32'(cam_sel2), 32'd0);
    wait_cond("done2", 4);
    check("a16_error", 32'(error2), 32'd0);
    check("a16_err_cam", 32'(err_cam2), 32'd0);
    check("a16_busy", 32'(busy2), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cam_config_seq.md
CAM_CONFIG_SEQ -- requirements
Module: cam_config_seq

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 25000000, meaning clk frequency in Hz, used for delay timing.
REQ-002 The block SHALL have parameter I2C_ADDR_16, default 0, meaning register address width select: 0 = 8-bit, 1 = 16-bit.
REQ-003 The block SHALL have parameter NUM_CAMS, default 2, range 1..4, meaning number of cameras configured in turn.
REQ-004 The block SHALL have parameter ROM_AW, default 10, meaning ROM address width.
REQ-005 The block SHALL have parameter MAX_RETRY, default 3, meaning SCCB retries allowed per entry after a NACK.
REQ-006 The block SHALL have the following ports, with CW = max(1, clog2(NUM_CAMS)) and DW = 16+8*I2C_ADDR_16:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  level/pulse; begins a full sequence when idle.
- rom_addr  out  ROM_AW  configuration table address.
- rom_data  in  DW  table word, valid one cycle after rom_addr changes (synchronous ROM).
- cam_sel  out  CW  camera currently addressed; steers the SCCB mux.
- sccb_ready  in  1  SCCB master idle.
- sccb_nack  in  1  NACK result of the last transfer, valid while sccb_ready=1.
- sccb_addr  out  DW-8  register address.
- sccb_data  out  8  register data.
- sccb_start  out  1  single-cycle transfer request.
- busy  out  1  sequence in progress.
- done  out  1  sequence finished; sticky.
- error  out  1  sequence aborted on retry exhaustion; sticky.
- err_cam  out  CW  camera that failed.

Function
REQ-007 The FSM SHALL have the states IDLE, FETCH, DECODE, SEND, WAIT_LO, WAIT_HI, TIMER, NEXT_CAM and FIN.
REQ-008 In IDLE, start=1 SHALL clear done, error and err_cam, set rom_addr=0, cam_sel=0 and retry=0, set busy=1, and go to FETCH.
REQ-009 FETCH SHALL be a one-cycle ROM latency wait that always goes to DECODE.
REQ-010 DECODE with rom_data[15:0]=16'hFFFF SHALL load timer=CLK_FREQ/20 (50 ms) and go to TIMER, returning to NEXT_CAM.
REQ-011 DECODE with rom_data[15:0]=16'hFFF0 SHALL load timer=CLK_FREQ/100 (10 ms), increment rom_addr and go to TIMER, returning to FETCH.
REQ-012 DECODE with any other rom_data SHALL latch sccb_addr=rom_data[DW-1:8] and sccb_data=rom_data[7:0], then go to SEND.
REQ-013 SEND SHALL wait for sccb_ready=1, then drive sccb_start=1 for exactly one cycle and go to WAIT_LO.
REQ-014 WAIT_LO SHALL wait for sccb_ready=0; if sccb_ready is still 1 after 4 cycles, the block SHALL treat the transfer as started and go to WAIT_HI.
REQ-015 WAIT_HI SHALL wait for sccb_ready=1, then sample sccb_nack on that cycle.
REQ-016 On ACK (sccb_nack=0), the block SHALL increment rom_addr, clear retry and go to FETCH.
REQ-017 On NACK with retry<MAX_RETRY, the block SHALL increment retry, keep rom_addr and go to SEND, re-sending the same entry.
REQ-018 On NACK with retry=MAX_RETRY, the block SHALL set error=1 and err_cam=cam_sel, and go to FIN.
REQ-019 TIMER SHALL decrement a 32-bit timer each cycle and leave on the cycle timer==0 to the stored return state, so a load of N gives N+1 cycles in TIMER.
REQ-020 NEXT_CAM with cam_sel<NUM_CAMS-1 SHALL increment cam_sel, set rom_addr=0 and go to FETCH, so the same table is replayed for each camera.
REQ-021 NEXT_CAM with cam_sel=NUM_CAMS-1 SHALL go to FIN.
REQ-022 FIN SHALL set done=1 and busy=0 for one cycle, then go to IDLE; done and error SHALL hold until the next accepted start.
REQ-023 The block SHALL ignore start outside IDLE.
REQ-024 sccb_start SHALL never be asserted in any state other than SEND.
REQ-025 rom_addr SHALL wrap modulo 2^ROM_AW with no special handling, since tables are required to contain 16'hFFFF.
REQ-026 With NUM_CAMS=1, cam_sel and err_cam SHALL be held at 0.

Reset
REQ-027 rst_n=0 SHALL asynchronously force state=IDLE, rom_addr=0, cam_sel=0, retry=0, timer=0, sccb_addr=0, sccb_data=0, sccb_start=0, busy=0, done=0, error=0 and err_cam=0.
REQ-028 When reset asserts mid-transfer, the block SHALL release sccb_start immediately and SHALL NOT retain any partial-sequence state after rst_n rises.
REQ-029 After rst_n rises, the block SHALL wait in IDLE for start.

Verification
REQ-030 NUM_CAMS=2, table {1280, 12A5, FFFF}, always ACK -> 2 transfers per camera with cam_sel 0 then 1, done=1, error=0; the 50 ms gap between cameras is CLK_FREQ/20+1 cycles.
REQ-031 Entry FFF0 between two writes -> exactly CLK_FREQ/100+1 TIMER cycles with no sccb_start.
REQ-032 NACK on the 2nd entry twice, then ACK -> 3 sccb_start pulses carry the same addr/data, and the sequence completes with error=0.
REQ-033 Permanent NACK on camera 1 with MAX_RETRY=3 -> 4 attempts, then error=1, err_cam=1, done=1, busy=0.
REQ-034 I2C_ADDR_16=1, word 24'h300A56 -> sccb_addr=16'h300A, sccb_data=8'h56.
REQ-035 rst_n pulsed low during WAIT_HI -> all outputs 0 at once; a new start then restarts the sequence at rom_addr=0, cam_sel=0.
